// File: rtl/pipo_load_arbiter_pkg.sv
// Shared definitions for the round-robin PIPO load arbiter: state encoding,
// width helper and default parameter values.
package pipo_load_arbiter_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  localparam int WIDTH_DEF       = 4;
  localparam int NUM_REQ_DEF     = 4;
  localparam int HOLD_CYCLES_DEF = 3;

  // Bits needed to index n values; never narrower than one bit.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/pipo_load_arbiter_rr_pick.sv
// Rotate-priority encoder: first set request at or after ptr, wrapping
// modulo NUM_REQ.
module pipo_load_arbiter_rr_pick
  import pipo_load_arbiter_pkg::*;
#(
  parameter  int NUM_REQ = NUM_REQ_DEF,
  localparam int PW      = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PW-1:0]      ptr,
  output logic               any,
  output logic [PW-1:0]      winner
);

  logic [PW-1:0] idx;

  // Scan from the farthest candidate back to ptr so the nearest one wins.
  always_comb begin
    any    = 1'b0;
    winner = '0;
    idx    = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = PW'((int'(ptr) + k) % NUM_REQ);
      if (req[idx]) begin
        any    = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/pipo_load_arbiter.sv
// Shared WIDTH-bit holding register loaded by round-robin grant, then held
// for HOLD_CYCLES cycles before the next arbitration.
module pipo_load_arbiter
  import pipo_load_arbiter_pkg::*;
#(
  parameter  int WIDTH       = WIDTH_DEF,
  parameter  int NUM_REQ     = NUM_REQ_DEF,
  parameter  int HOLD_CYCLES = HOLD_CYCLES_DEF,
  localparam int PW          = clog2(NUM_REQ)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*WIDTH-1:0]   din,
  output logic [NUM_REQ-1:0]         ack,
  output logic [WIDTH-1:0]           q,
  output logic                       q_valid,
  output logic [PW-1:0]              owner,
  output logic                       busy
);

  localparam int CW = clog2(HOLD_CYCLES + 1);

  state_e               state_q, state_d;
  logic [PW-1:0]        ptr_q, ptr_d;
  logic [PW-1:0]        owner_q, owner_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [WIDTH-1:0]     q_q, q_d;
  logic                 q_valid_q, q_valid_d;
  logic [NUM_REQ-1:0]   ack_q, ack_d;
  logic                 any;
  logic [PW-1:0]        win;
  logic [WIDTH-1:0]     din_arr [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign din_arr[i] = din[i*WIDTH +: WIDTH];
  end

  pipo_load_arbiter_rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
    .req    (req),
    .ptr    (ptr_q),
    .any    (any),
    .winner (win)
  );

  // clr dominates everything but rst; req is only looked at in IDLE.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    cnt_d     = cnt_q;
    q_d       = q_q;
    q_valid_d = q_valid_q;
    ack_d     = '0;
    if (clr) begin
      state_d   = ST_IDLE;
      cnt_d     = '0;
      q_d       = '0;
      q_valid_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (any) begin
            q_d        = din_arr[win];
            owner_d    = win;
            q_valid_d  = 1'b1;
            ack_d[win] = 1'b1;
            ptr_d      = (int'(win) == NUM_REQ - 1) ? '0 : PW'(int'(win) + 1);
            cnt_d      = CW'(HOLD_CYCLES - 1);
            state_d    = ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (cnt_q == '0) state_d = ST_IDLE;
          else             cnt_d   = cnt_q - CW'(1);
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      owner_q   <= '0;
      cnt_q     <= '0;
      q_q       <= '0;
      q_valid_q <= 1'b0;
      ack_q     <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      owner_q   <= owner_d;
      cnt_q     <= cnt_d;
      q_q       <= q_d;
      q_valid_q <= q_valid_d;
      ack_q     <= ack_d;
    end
  end

  assign ack     = ack_q;
  assign q       = q_q;
  assign q_valid = q_valid_q;
  assign owner   = owner_q;
  assign busy    = (state_q == ST_HOLD);

endmodule

// File: tb/tb_pipo_load_arbiter.sv
// Scoreboard bench for pipo_load_arbiter (WIDTH=4, NUM_REQ=4, HOLD_CYCLES=3):
// directed cycles push hand-computed post-edge outputs; a monitor compares.
module tb_pipo_load_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr = 1'b0;
  logic [3:0]  req = '0;
  logic [15:0] din = '0;
  logic [3:0]  ack;
  logic [3:0]  q;
  logic        q_valid;
  logic [1:0]  owner;
  logic        busy;

  typedef struct {
    string      nm;
    logic [3:0] q;
    logic       qv;
    logic [3:0] ack;
    logic [1:0] owner;
    logic       busy;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  bit   stim_done = 1'b0;

  always #5 clk = ~clk;

  pipo_load_arbiter #(.WIDTH(4), .NUM_REQ(4), .HOLD_CYCLES(3)) dut (
    .clk     (clk),
    .rst     (rst),
    .clr     (clr),
    .req     (req),
    .din     (din),
    .ack     (ack),
    .q       (q),
    .q_valid (q_valid),
    .owner   (owner),
    .busy    (busy)
  );

  task automatic check(input string nm, input string fld, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s.%s actual=%0h required=%0h", nm, fld, act, exp);
  endtask

  // Drive one cycle of inputs and record the outputs expected after the edge.
  task automatic cyc(input logic r, input logic c, input logic [3:0] rq,
                     input logic [3:0] eq, input logic ev, input logic [3:0] ea,
                     input logic [1:0] eo, input logic eb, input string nm);
    exp_t e;
    @(negedge clk);
    rst = r; clr = c; req = rq;
    e.nm = nm; e.q = eq; e.qv = ev; e.ack = ea; e.owner = eo; e.busy = eb;
    sb.push_back(e);
  endtask

  // Two remaining HOLD cycles then the return to IDLE, with q/owner held.
  task automatic tail3(input logic [3:0] rq, input logic [3:0] eq, input logic [1:0] eo, input string nm);
    cyc(0, 0, rq, eq, 1, 4'b0000, eo, 1, {nm, "_h2"});
    cyc(0, 0, rq, eq, 1, 4'b0000, eo, 1, {nm, "_h3"});
    cyc(0, 0, rq, eq, 1, 4'b0000, eo, 0, {nm, "_idle"});
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check(e.nm, "q",       32'(q),       32'(e.q));
        check(e.nm, "q_valid", 32'(q_valid), 32'(e.qv));
        check(e.nm, "ack",     32'(ack),     32'(e.ack));
        check(e.nm, "owner",   32'(owner),   32'(e.owner));
        check(e.nm, "busy",    32'(busy),    32'(e.busy));
      end
    end
  end

  initial begin : stim
    // 1: reset dominates a full request vector
    din = {4'hB, 4'hA, 4'h9, 4'h8};
    cyc(1, 0, 4'b1111, 4'h0, 0, 4'b0000, 2'd0, 0, "rst_a");
    cyc(1, 0, 4'b1111, 4'h0, 0, 4'b0000, 2'd0, 0, "rst_b");

    // 2: single request, one-cycle latency, busy for three cycles
    din = {4'hB, 4'hA, 4'h9, 4'hA};
    cyc(0, 0, 4'b0001, 4'hA, 1, 4'b0001, 2'd0, 1, "load0");
    tail3(4'b0000, 4'hA, 2'd0, "load0");
    cyc(0, 0, 4'b0000, 4'hA, 1, 4'b0000, 2'd0, 0, "idle_keep");

    // 3: all requesting, rotation 0,1,2,3,0 at four-cycle spacing
    din = {4'hB, 4'hA, 4'h9, 4'h8};
    cyc(1, 0, 4'b0000, 4'h0, 0, 4'b0000, 2'd0, 0, "rst_c");
    for (int k = 0; k < 5; k++) begin
      logic [1:0] o;
      logic [3:0] a;
      o = 2'(k % 4);
      a = 4'b0001 << o;
      cyc(0, 0, 4'b1111, 4'h8 + 4'(o), 1, a, o, 1, $sformatf("rr%0d", k));
      tail3(4'b1111, 4'h8 + 4'(o), o, $sformatf("rr%0d", k));
    end

    // 4: grant to 2 leaves ptr=3, so 0 beats 2 next, then 2 follows
    cyc(0, 0, 4'b0100, 4'hA, 1, 4'b0100, 2'd2, 1, "g2");
    tail3(4'b0101, 4'hA, 2'd2, "g2");
    cyc(0, 0, 4'b0101, 4'h8, 1, 4'b0001, 2'd0, 1, "wrap0");
    tail3(4'b0100, 4'h8, 2'd0, "wrap0");
    cyc(0, 0, 4'b0100, 4'hA, 1, 4'b0100, 2'd2, 1, "then2");
    tail3(4'b0000, 4'hA, 2'd2, "then2");

    // 5: clr in the second HOLD cycle, pending req=0010
    cyc(0, 0, 4'b1000, 4'hB, 1, 4'b1000, 2'd3, 1, "g3");
    cyc(0, 0, 4'b0010, 4'hB, 1, 4'b0000, 2'd3, 1, "g3_h2");
    cyc(0, 1, 4'b0010, 4'h0, 0, 4'b0000, 2'd3, 0, "clr_hold");
    cyc(0, 0, 4'b0010, 4'h9, 1, 4'b0010, 2'd1, 1, "after_clr");
    tail3(4'b0000, 4'h9, 2'd1, "after_clr");
    // clr beats a request in IDLE; ptr=2 then picks 0
    cyc(0, 1, 4'b0001, 4'h0, 0, 4'b0000, 2'd1, 0, "clr_idle");
    cyc(0, 0, 4'b0001, 4'h8, 1, 4'b0001, 2'd0, 1, "post_clr_idle");
    tail3(4'b0000, 4'h8, 2'd0, "post_clr_idle");

    // 6: reset mid-HOLD after a grant to 3; ptr returns to 0
    cyc(0, 0, 4'b1000, 4'hB, 1, 4'b1000, 2'd3, 1, "g3b");
    cyc(1, 0, 4'b1010, 4'h0, 0, 4'b0000, 2'd0, 0, "rst_mid");
    cyc(0, 0, 4'b1010, 4'h9, 1, 4'b0010, 2'd1, 1, "post_rst");
    tail3(4'b0000, 4'h9, 2'd1, "post_rst");

    stim_done = 1'b1;
  end

  initial begin : finisher
    int guard;
    wait (stim_done);
    guard = 0;
    while (sb.size() > 0 && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    #2;
    if (sb.size() > 0) begin
      n_checks++;
      $display("FAIL drain pending=%0d required=0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog time_limit reached");
    $fatal(1, "timeout");
  end

endmodule
